// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch and
// the data (load/store) port. Data normally wins; a fetch that has lost
// STARVE_LIMIT consecutive arbitrations is forced through on the next one.
// A flush during an in-flight fetch lets the memory finish but suppresses the
// response, so the memory side never sees an aborted transaction.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_stall,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    F_BUSY,
    D_BUSY,
    F_RESP,
    D_RESP
  } state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  logic [3:0]  r_starveCnt;
  logic        r_cancel;
  logic        r_mReq;
  logic        r_mWe;
  logic [31:0] r_mAddr;
  logic [31:0] r_mWdata;
  logic [3:0]  r_mWstrb;
  logic [31:0] r_ifRdata;
  logic [31:0] r_dRdata;

  logic w_fetchWants;
  logic w_fetchWins;
  logic w_cancelNow;

  // A flushed fetch request is not a candidate; fetch only beats a waiting
  // data request once it has been starved for the full limit. A flush that
  // lands on the same cycle as m_ready still cancels the response.
  assign w_fetchWants = if_req & ~if_flush;
  assign w_fetchWins  = w_fetchWants & (~d_req | (r_starveCnt == LP_LIMIT));
  assign w_cancelNow  = r_cancel | if_flush;

  // Arbitration FSM: latches the winner's attributes, holds them until the
  // memory completes, then gives a single response cycle to the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_starveCnt <= '0;
      r_cancel    <= 1'b0;
      r_mReq      <= 1'b0;
      r_mWe       <= 1'b0;
      r_mAddr     <= '0;
      r_mWdata    <= '0;
      r_mWstrb    <= '0;
      r_ifRdata   <= '0;
      r_dRdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fetchWins) begin
            r_state     <= F_BUSY;
            r_mReq      <= 1'b1;
            r_mWe       <= 1'b0;
            r_mAddr     <= if_addr;
            r_mWdata    <= '0;
            r_mWstrb    <= '0;
            r_starveCnt <= '0;
            r_cancel    <= 1'b0;
          end else if (d_req) begin
            r_state  <= D_BUSY;
            r_mReq   <= 1'b1;
            r_mWe    <= d_we;
            r_mAddr  <= d_addr;
            r_mWdata <= d_wdata;
            r_mWstrb <= d_we ? d_wstrb : 4'b0000;
            if (w_fetchWants && (r_starveCnt < LP_LIMIT)) begin
              r_starveCnt <= r_starveCnt + 4'd1;
            end
          end
        end
        F_BUSY: begin
          if (m_ready) begin
            r_mReq   <= 1'b0;
            r_cancel <= 1'b0;
            if (w_cancelNow) begin
              r_state <= IDLE;
            end else begin
              r_state   <= F_RESP;
              r_ifRdata <= m_rdata;
            end
          end else if (if_flush) begin
            r_cancel <= 1'b1;
          end
        end
        D_BUSY: begin
          if (m_ready) begin
            r_mReq  <= 1'b0;
            r_state <= D_RESP;
            if (!r_mWe) begin
              r_dRdata <= m_rdata;
            end
          end
        end
        F_RESP:  r_state <= IDLE;
        D_RESP:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_req    = r_mReq;
  assign m_we     = r_mWe;
  assign m_addr   = r_mAddr;
  assign m_wdata  = r_mWdata;
  assign m_wstrb  = r_mWstrb;
  assign if_rdata = r_ifRdata;
  assign d_rdata  = r_dRdata;

  assign busy     = (r_state != IDLE);
  assign d_ack    = (r_state == D_RESP);
  assign if_ack   = (r_state == F_RESP) & ~if_flush;
  assign if_stall = if_req & ~if_ack & ~if_flush;
  assign d_stall  = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with a transaction-level
// reference model, a latency-programmable memory responder, a per-cycle
// comparator and literal expectations for the key scenarios.
module tb_mem_arbiter;

  localparam int LIMIT = 4;
  localparam int NONE  = 0;
  localparam int FETCH = 1;
  localparam int DATA  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_stall;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;

  int memLatency = 0;
  int waitCnt = 0;
  int spuriousReq = 0;
  int spuriousDone = 0;
  int cycleNo = 0;

  int          mOwner = NONE;
  int          mResp = NONE;
  int          mStarve = 0;
  bit          mCancelled = 1'b0;
  logic [31:0] mAddr = '0;
  logic [31:0] mWdata = '0;
  logic        mWe = 1'b0;
  logic [3:0]  mWstrb = '0;
  logic [31:0] mIfData = '0;
  logic [31:0] mDData = '0;

  logic [31:0] grantAddr[$];
  logic        grantWe[$];
  logic        prevMReq = 1'b0;
  int          ifAckCount = 0;
  int          dAckCount = 0;
  int          lastLatency = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0300: return 32'h1234_5678;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr, input logic ifFlush,
                               input logic dReq, input logic dWe, input logic [31:0] dAddr,
                               input logic [31:0] dWdata, input logic [3:0] dWstrb);
    if_req   = ifReq;
    if_addr  = ifAddr;
    if_flush = ifFlush;
    d_req    = dReq;
    d_we     = dWe;
    d_addr   = dAddr;
    d_wdata  = dWdata;
    d_wstrb  = dWstrb;
  endtask

  // Runs requesters until each wanted one is acknowledged, dropping its request after its ack.
  task automatic serviceUntil(input bit wantF, input bit wantD, input int budget, input string name);
    bit fDone;
    bit dDone;
    bit gotF;
    bit gotD;
    int n;
    fDone = !wantF;
    dDone = !wantD;
    n = 0;
    while (!(fDone && dDone)) begin
      if (n >= budget) begin
        timeoutFail(name);
        break;
      end
      @(negedge clk);
      n++;
      gotF = !fDone && (if_ack === 1'b1);
      gotD = !dDone && (d_ack === 1'b1);
      if (gotF) fDone = 1'b1;
      if (gotD) dDone = 1'b1;
      tick();
      if (gotF) if_req = 1'b0;
      if (gotD) d_req = 1'b0;
    end
    lastLatency = n;
  endtask

  // Memory responder: answers m_req after memLatency wait cycles, or fires a stray m_ready on request.
  always @(posedge clk) begin
    #1;
    cycleNo++;
    if (spuriousReq != spuriousDone) begin
      m_ready = 1'b1;
      m_rdata = 32'hFFFF_FFFF;
      spuriousDone++;
    end else if (m_req !== 1'b1) begin
      waitCnt = 0;
      m_ready = 1'b0;
      m_rdata = 32'hCAFE_0000 + 32'(cycleNo);
    end else if (waitCnt >= memLatency) begin
      m_ready = 1'b1;
      m_rdata = memRead(m_addr);
      waitCnt = 0;
    end else begin
      waitCnt++;
      m_ready = 1'b0;
      m_rdata = 32'hCAFE_0000 + 32'(cycleNo);
    end
  end

  // Reference model: tracks who owns the memory, who is owed a response and the starvation count.
  always @(posedge clk) begin
    if (rst) begin
      mOwner = NONE; mResp = NONE; mStarve = 0; mCancelled = 1'b0;
      mAddr = '0; mWdata = '0; mWe = 1'b0; mWstrb = '0; mIfData = '0; mDData = '0;
    end else if (mResp != NONE) begin
      mResp = NONE;
    end else if (mOwner == NONE) begin
      if (if_req && !if_flush && (!d_req || mStarve == LIMIT)) begin
        mOwner = FETCH; mStarve = 0; mCancelled = 1'b0;
        mAddr = if_addr; mWe = 1'b0; mWstrb = '0;
      end else if (d_req) begin
        mOwner = DATA;
        if (if_req && !if_flush && mStarve < LIMIT) mStarve++;
        mAddr = d_addr; mWe = d_we; mWdata = d_wdata; mWstrb = d_we ? d_wstrb : 4'h0;
      end
    end else begin
      if (mOwner == FETCH && if_flush) mCancelled = 1'b1;
      if (m_ready) begin
        if (mOwner == DATA) begin
          if (!mWe) mDData = m_rdata;
          mResp = DATA;
        end else if (!mCancelled) begin
          mIfData = m_rdata;
          mResp = FETCH;
        end
        mOwner = NONE;
        mCancelled = 1'b0;
      end
    end
  end

  // Grant log: records the address and direction of every new memory request.
  always @(negedge clk) begin
    if (m_req === 1'b1 && prevMReq !== 1'b1) begin
      grantAddr.push_back(m_addr);
      grantWe.push_back(m_we);
    end
    prevMReq = m_req;
  end

  // Per-cycle comparison of every DUT output against the reference model.
  always @(negedge clk) begin
    logic expIfAck;
    logic expDAck;
    expIfAck = (mResp == FETCH) && !if_flush;
    expDAck  = (mResp == DATA);
    checkOutput("m_req", m_req, (mOwner != NONE));
    if (mOwner != NONE) begin
      checkOutput("m_addr", m_addr, mAddr);
      checkOutput("m_we", m_we, mWe);
      checkOutput("m_wstrb", m_wstrb, mWstrb);
      if (mWe) checkOutput("m_wdata", m_wdata, mWdata);
    end
    checkOutput("busy", busy, (mOwner != NONE) || (mResp != NONE));
    checkOutput("if_ack", if_ack, expIfAck);
    checkOutput("d_ack", d_ack, expDAck);
    checkOutput("if_stall", if_stall, if_req & ~expIfAck & ~if_flush);
    checkOutput("d_stall", d_stall, d_req & ~expDAck);
    checkOutput("if_rdata", if_rdata, mIfData);
    checkOutput("d_rdata", d_rdata, mDData);
    if (if_ack === 1'b1) ifAckCount++;
    if (d_ack === 1'b1) dAckCount++;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int ackBefore;
    int fetches;
    int n;
    bit gotF;
    bit gotD;
    logic [31:0] expC [10];

    // Reset state
    tick();
    tick();
    @(negedge clk);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstMReq", m_req, 1'b0);
    checkOutput("rstIfRdata", if_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // Fetch only, zero wait states: ack on the third cycle
    $display("[TB] fetch only");
    memLatency = 0;
    base = grantAddr.size();
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    serviceUntil(1'b1, 1'b0, 20, "fetchOnly");
    checkOutput("fetchLatency", lastLatency, 3);
    checkOutput("fetchData", if_rdata, 32'h0050_0093);
    checkOutput("fetchAddr", grantAddr[base], 32'h100);
    tick();

    // Simultaneous store and fetch: data first, then fetch
    $display("[TB] simultaneous requests");
    base = grantAddr.size();
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF);
    serviceUntil(1'b1, 1'b1, 30, "simultaneous");
    checkOutput("simFirstAddr", grantAddr[base], 32'h200);
    checkOutput("simFirstWe", grantWe[base], 1'b1);
    checkOutput("simSecondAddr", grantAddr[base + 1], 32'h104);
    checkOutput("simFetchData", if_rdata, 32'hA5A5_0104);
    tick();

    // Starvation: continuous data traffic with a waiting fetch, two rounds
    $display("[TB] starvation");
    base = grantAddr.size();
    expC = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h108,
             32'h410, 32'h414, 32'h418, 32'h41C, 32'h10C};
    applyStimulus(1'b1, 32'h108, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    fetches = 0;
    n = 0;
    while (fetches < 2 && n < 200) begin
      @(negedge clk);
      n++;
      gotF = (if_ack === 1'b1);
      gotD = (d_ack === 1'b1);
      tick();
      if (gotD) d_addr = d_addr + 32'd4;
      if (gotF) begin
        fetches++;
        if_addr = if_addr + 32'd4;
      end
    end
    if (fetches < 2) timeoutFail("starvation");
    if_req = 1'b0;
    d_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (base + i < grantAddr.size()) checkOutput($sformatf("starveGrant%0d", i), grantAddr[base + i], expC[i]);
      else timeoutFail($sformatf("starveGrant%0d", i));
    end
    tick();

    // Flush while a fetch is in flight: response suppressed, next fetch normal
    $display("[TB] flush in flight");
    memLatency = 3;
    ackBefore = ifAckCount;
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_req !== 1'b1 && n < 10);
    if (m_req !== 1'b1) timeoutFail("flushGrant");
    tick();
    if_flush = 1'b1;
    if_req = 1'b0;
    tick();
    if_flush = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 20);
    if (busy !== 1'b0) timeoutFail("flushIdle");
    checkOutput("flushNoAck", ifAckCount - ackBefore, 0);
    checkOutput("flushKeepsData", if_rdata, 32'hA5A5_010C);
    tick();
    memLatency = 0;
    applyStimulus(1'b1, 32'h504, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    serviceUntil(1'b1, 1'b0, 20, "afterFlush");
    checkOutput("afterFlushData", if_rdata, 32'hA5A5_0504);
    tick();

    // Load with five wait states
    $display("[TB] wait states");
    memLatency = 5;
    base = grantAddr.size();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h1111_2222, 4'hF);
    serviceUntil(1'b0, 1'b1, 30, "waitStates");
    checkOutput("waitLatency", lastLatency, 8);
    checkOutput("waitData", d_rdata, 32'h1234_5678);
    checkOutput("waitAddr", grantAddr[base], 32'h300);
    tick();

    // Stray m_ready while idle is ignored
    $display("[TB] stray m_ready");
    spuriousReq++;
    tick();
    tick();
    @(negedge clk);
    checkOutput("strayBusy", busy, 1'b0);
    checkOutput("strayDData", d_rdata, 32'h1234_5678);
    tick();

    // Reset in the middle of a store
    $display("[TB] reset during data access");
    memLatency = 5;
    ackBefore = dAckCount;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h600, 32'h0BAD_F00D, 4'h3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_req !== 1'b1 && n < 10);
    if (m_req !== 1'b1) timeoutFail("rstGrant");
    tick();
    rst = 1'b1;
    d_req = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstMReq", m_req, 1'b0);
    checkOutput("midRstBusy", busy, 1'b0);
    checkOutput("midRstDRdata", d_rdata, 32'h0);
    repeat (8) tick();
    checkOutput("midRstNoAck", dAckCount - ackBefore, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
